// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_err,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, bus_err,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: req/ack bus transaction with pipeline stall and load extension.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               dmu_mode,
  input  logic                     dmwe,
  input  logic                     dmrd,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_data,
  output logic [31:0]              ld_data,
  output logic                     ld_valid,
  output logic                     mem_stall,
  output logic                     misalign,
  mem_access_unit_if.master        bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [2:0]  mode_p1;
  logic [1:0]  off_p1;
  logic        legal;
  logic        aligned;
  logic        access;
  logic        start;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
`endif

  function automatic logic [3:0] store_strb(input logic [2:0] mode, input logic [1:0] off);
    case (mode[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] data);
    case (mode[1:0])
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (mode)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    legal = dmu_mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (dmu_mode[1:0])
      2'b01:   aligned = ~dm_addr[0];
      2'b10:   aligned = (dm_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    access    = dmrd | dmwe;
    start     = ~rst & (state == IDLE) & access & legal & aligned;
    misalign  = ~rst & (state == IDLE) & access & legal & ~aligned;
    mem_stall = (state == WAIT) | start;
  end

`ifndef MEM_TIMEOUT_EN
  assign bus.bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_wstrb <= 4'b0;
      bus.bus_addr  <= 32'b0;
      bus.bus_wdata <= 32'b0;
      ld_valid      <= 1'b0;
      ld_data       <= 32'b0;
      mode_p1       <= 3'b0;
      off_p1        <= 2'b0;
`ifdef MEM_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
      cnt           <= '0;
`endif
    end else begin
      ld_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus.bus_err <= 1'b0;
`endif
      case (state)
        // IDLE -> WAIT: latch the request attributes (store wins when both are set)
        IDLE: begin
          if (start) begin
            bus.bus_addr  <= {dm_addr[31:2], 2'b00};
            bus.bus_we    <= dmwe;
            bus.bus_wstrb <= dmwe ? store_strb(dmu_mode, dm_addr[1:0]) : 4'b0;
            bus.bus_wdata <= dmwe ? store_data(dmu_mode, dm_data) : 32'b0;
            bus.bus_req   <= 1'b1;
            mode_p1       <= dmu_mode;
            off_p1        <= dm_addr[1:0];
            state         <= WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt           <= '0;
`endif
          end
        end
        // WAIT -> DONE: capture the extended load word on ack
        WAIT: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            ld_valid    <= ~bus.bus_we;
            ld_data     <= bus.bus_we ? 32'b0 : load_extend(mode_p1, off_p1, bus.bus_rdata);
            state       <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.bus_req <= 1'b0;
            bus.bus_err <= 1'b1;
            ld_valid    <= ~bus.bus_we;
            ld_data     <= 32'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        // DONE -> IDLE unconditionally so the frozen EX/MEM instruction is not replayed
        DONE: begin
          ld_data <= 32'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a spec-level access model and per-cycle compare.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dmu_mode;
  logic        dmwe, dmrd;
  logic [31:0] dm_addr, dm_data;
  logic [31:0] ld_data;
  logic        ld_valid, mem_stall, misalign;

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .dmu_mode  (dmu_mode),
    .dmwe      (dmwe),
    .dmrd      (dmrd),
    .dm_addr   (dm_addr),
    .dm_data   (dm_data),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .mem_stall (mem_stall),
    .misalign  (misalign),
    .bus       (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Spec-level model of one access
  function automatic bit m_legal(input logic [2:0] m);
    return (m == 3'b000) || (m == 3'b001) || (m == 3'b010) || (m == 3'b100) || (m == 3'b101);
  endfunction

  function automatic int m_size(input logic [2:0] m);
    if (m[1:0] == 2'b00) return 1;
    if (m[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_aligned(input logic [2:0] m, input logic [31:0] a);
    return (int'(a[1:0]) % m_size(m)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] m, input logic [31:0] a);
    logic [3:0] s;
    int off;
    off = int'(a[1:0]);
    s = 4'b0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + m_size(m)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = 32'b0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % m_size(m)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] m, input logic [31:0] a,
                                         input logic [31:0] w);
    longint v, span;
    int n;
    n = m_size(m);
    span = 64'sd1 <<< (8 * n);
    v = longint'({32'b0, w}) >>> (8 * int'(a[1:0]));
    v = v % span;
    if (!m[2] && n < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Expectations consumed by the compare process
  logic        chk_en = 1'b0;
  logic        e_stall = 0, e_mis = 0, e_req = 0, e_ldv = 0, e_err = 0, e_we = 0, e_ld_chk = 1;
  logic [31:0] e_addr = 0, e_wdata = 0, e_ld = 0;
  logic [3:0]  e_strb = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_stall", 32'(mem_stall), 32'(e_stall));
      chk("misalign", 32'(misalign), 32'(e_mis));
      chk("bus_req", 32'(bus.bus_req), 32'(e_req));
      chk("ld_valid", 32'(ld_valid), 32'(e_ldv));
      chk("bus_err", 32'(bus.bus_err), 32'(e_err));
      if (e_ld_chk) chk("ld_data", ld_data, e_ld);
      if (e_req) begin
        chk("bus_addr", bus.bus_addr, e_addr);
        chk("bus_we", 32'(bus.bus_we), 32'(e_we));
        if (e_we) begin
          chk("bus_wstrb", 32'(bus.bus_wstrb), 32'(e_strb));
          chk("bus_wdata", bus.bus_wdata, e_wdata);
        end
      end
    end
  end

  // Observations from the most recent access
  int          obs_stalls, obs_reqs;
  logic [31:0] obs_ld, obs_wdata;
  logic [3:0]  obs_strb;
  logic        obs_ldv, obs_mis, obs_we, obs_err;

  task automatic idle_exp();
    dmrd = 1'b0; dmwe = 1'b0; dmu_mode = 3'b000; dm_addr = 32'b0; dm_data = 32'b0;
    e_stall = 0; e_mis = 0; e_req = 0; e_ldv = 0; e_err = 0; e_we = 0;
    e_ld_chk = 1; e_ld = 32'b0;
  endtask

  // Starts at posedge+1 of an IDLE cycle, returns at posedge+1 of the following turnaround cycle.
  // ack_at = 0 means the memory never acknowledges.
  task automatic access(input logic [2:0] m, input logic we, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input int ack_at, input logic [31:0] rdata);
    bit go, mis, to;
    int nw;
    go  = (we | rd) && m_legal(m) && m_aligned(m, a);
    mis = (we | rd) && m_legal(m) && !m_aligned(m, a);
    to  = (ack_at == 0);
    nw  = to ? TO : ack_at;
    obs_stalls = 0; obs_reqs = 0; obs_ld = 32'b0; obs_ldv = 0; obs_err = 0;
    obs_we = 0; obs_strb = 4'b0; obs_wdata = 32'b0;
    dmu_mode = m; dmwe = we; dmrd = rd; dm_addr = a; dm_data = d;
    e_stall = go; e_mis = mis; e_req = 0; e_ldv = 0; e_err = 0; e_ld_chk = 1; e_ld = 32'b0;
    #1;
    obs_stalls += int'(mem_stall);
    obs_mis = misalign;
    if (go) begin
      for (int w = 1; w <= nw; w++) begin
        @(posedge clk); #1;
        e_stall = 1; e_mis = 0; e_req = 1; e_we = we;
        e_addr = {a[31:2], 2'b00}; e_strb = m_strb(m, a); e_wdata = m_wdata(m, d);
        if (w == ack_at) begin
          bus.bus_ack = 1'b1;
          bus.bus_rdata = rdata;
        end
        #1;
        obs_stalls += int'(mem_stall);
        obs_reqs += int'(bus.bus_req);
        if (w == 1) begin
          obs_we = bus.bus_we; obs_strb = bus.bus_wstrb; obs_wdata = bus.bus_wdata;
        end
      end
      @(posedge clk); #1;
      bus.bus_ack = 1'b0;
      bus.bus_rdata = $urandom;
      e_stall = 0; e_req = 0; e_mis = 0;
      e_ldv = !we; e_err = to;
      e_ld_chk = !we || to;
      e_ld = to ? 32'b0 : m_load(m, a, rdata);
      #1;
      obs_stalls += int'(mem_stall);
      obs_ld = ld_data; obs_ldv = ld_valid; obs_err = bus.bus_err;
    end
    @(posedge clk); #1;
    obs_reqs += int'(bus.bus_req);
    idle_exp();
  endtask

  initial begin
    rst = 1'b1;
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'b0;
    idle_exp();
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_bus_req", 32'(bus.bus_req), 32'h0);
    chk("rst_bus_addr", bus.bus_addr, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    access(3'b010, 1'b0, 1'b1, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    chk("lw_stall_cycles", obs_stalls, 4);
    chk("lw_req_cycles", obs_reqs, 3);
    chk("lw_ld_data", obs_ld, 32'hDEADBEEF);
    chk("lw_ld_valid", 32'(obs_ldv), 1);

    access(3'b000, 1'b0, 1'b1, 32'h203, 32'h0, 1, 32'h80FF1234);
    chk("lb_ld_data", obs_ld, 32'hFFFFFF80);
    chk("lb_stall_cycles", obs_stalls, 2);
    access(3'b100, 1'b0, 1'b1, 32'h203, 32'h0, 2, 32'h80FF1234);
    chk("lbu_ld_data", obs_ld, 32'h00000080);
    access(3'b001, 1'b0, 1'b1, 32'h202, 32'h0, 1, 32'h80FF1234);
    chk("lh_ld_data", obs_ld, 32'hFFFF80FF);

    access(3'b000, 1'b1, 1'b0, 32'h302, 32'h000000A5, 2, 32'h0);
    chk("sb_we", 32'(obs_we), 1);
    chk("sb_wstrb", 32'(obs_strb), 32'h4);
    chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);
    chk("sb_ld_valid", 32'(obs_ldv), 0);

    access(3'b010, 1'b1, 1'b0, 32'h101, 32'h12345678, 1, 32'h0);
    chk("sw_mis_pulse", 32'(obs_mis), 1);
    chk("sw_mis_stall", obs_stalls, 0);
    chk("sw_mis_req", obs_reqs, 0);
    access(3'b001, 1'b0, 1'b1, 32'h201, 32'h0, 1, 32'h0);
    chk("lh_mis_pulse", 32'(obs_mis), 1);

    access(3'b101, 1'b0, 1'b1, 32'h102, 32'h0, 1, 32'h12345678);
    chk("lhu_ld_data", obs_ld, 32'h00001234);

    access(3'b011, 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'h0);
    chk("illegal_stall", obs_stalls, 0);
    chk("illegal_mis", 32'(obs_mis), 0);

    access(3'b010, 1'b1, 1'b1, 32'h500, 32'h11223344, 1, 32'h55667788);
    chk("both_we", 32'(obs_we), 1);
    chk("both_ld_valid", 32'(obs_ldv), 0);

    access(3'b001, 1'b1, 1'b0, 32'h506, 32'h0000BEEF, 1, 32'h0);
    chk("sh_wstrb", 32'(obs_strb), 32'hC);
    chk("sh_wdata", obs_wdata, 32'hBEEFBEEF);

    // Reset while in WAIT, then a stray ack
    dmu_mode = 3'b010; dmrd = 1'b1; dm_addr = 32'h400;
    e_stall = 1;
    @(posedge clk); #1;
    rst = 1'b1; dmrd = 1'b0;
    e_req = 1; e_stall = 1; e_we = 0; e_addr = 32'h400;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hFFFFFFFF;
    idle_exp();
    #1;
    chk("rstwait_bus_req", 32'(bus.bus_req), 32'h0);
    chk("rstwait_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    #1;
    chk("stray_ack_ld_valid", 32'(ld_valid), 32'h0);

    access(3'b010, 1'b0, 1'b1, 32'h600, 32'h0, 2, 32'hCAFEF00D);
    chk("post_rst_lw", obs_ld, 32'hCAFEF00D);

`ifdef MEM_TIMEOUT_EN
    access(3'b010, 1'b0, 1'b1, 32'h700, 32'h0, 0, 32'h0);
    chk("to_bus_err", 32'(obs_err), 1);
    chk("to_ld_data", obs_ld, 32'h0);
    chk("to_stall_cycles", obs_stalls, TO + 1);
    access(3'b010, 1'b0, 1'b1, 32'h704, 32'h0, TO, 32'h0BADF00D);
    chk("to_ack_wins_err", 32'(obs_err), 0);
    chk("to_ack_wins_data", obs_ld, 32'h0BADF00D);
`else
    access(3'b010, 1'b0, 1'b1, 32'h700, 32'h0, 10, 32'h0BADF00D);
    chk("long_wait_stalls", obs_stalls, 11);
    chk("long_wait_data", obs_ld, 32'h0BADF00D);
    chk("long_wait_err", 32'(obs_err), 0);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
